// File: rtl/dmem_access_unit_if.sv
// Request/response and SRAM bus bundle for dmem_access_unit.
// slave = the access unit itself; master = the pipeline/SRAM environment around it.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [3:0]        sram_w_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output sram_w_en, sram_addr, sram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  sram_w_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: one load/store per transaction, single SRAM access cycle.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned halfword/word accesses as errors.
module dmem_access_unit #(
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_access_unit_if.slave    bus,
  output logic [1:0]           state_dbg
);

  // Handshakes: a beat transfers on the posedge where valid && ready are both high;
  // valid never depends on ready, and ready is a pure function of the FSM state.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] RESP   = 2'b10;

  logic [1:0]        state;
  logic              l_we;
  logic [1:0]        l_size;
  logic              l_unsigned;
  logic              l_err;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        w_en_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [1:0]        span;
  logic [ADDR_W:0]   last_byte;
  logic              misalign;
  logic              req_err;
  logic [3:0]        req_en;
  logic [31:0]       ext_data;

  // Error and byte-enable decode for the request currently on the bus
  always_comb begin
    span   = 2'd0;
    req_en = 4'b0000;
    case (bus.req_size)
      2'b00:   begin span = 2'd0; req_en = 4'b0001; end
      2'b01:   begin span = 2'd1; req_en = 4'b0011; end
      2'b10:   begin span = 2'd3; req_en = 4'b1111; end
      default: begin span = 2'd0; req_en = 4'b0000; end
    endcase
    // Carry out of the top address bit means the access would wrap
    last_byte = {1'b0, bus.req_addr} + {{(ADDR_W-1){1'b0}}, span};
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_err = (bus.req_size == 2'b11) || last_byte[ADDR_W] || misalign;
  end

  always_comb begin
    ext_data = bus.sram_rdata;
    case (l_size)
      2'b00:   ext_data = {{24{~l_unsigned & bus.sram_rdata[7]}},  bus.sram_rdata[7:0]};
      2'b01:   ext_data = {{16{~l_unsigned & bus.sram_rdata[15]}}, bus.sram_rdata[15:0]};
      default: ext_data = bus.sram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      l_we       <= 1'b0;
      l_size     <= 2'b00;
      l_unsigned <= 1'b0;
      l_err      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      w_en_q     <= 4'b0000;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_we       <= bus.req_we;
            l_size     <= bus.req_size;
            l_unsigned <= bus.req_unsigned;
            l_err      <= req_err;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            w_en_q     <= (bus.req_we && !req_err) ? req_en : 4'b0000;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          w_en_q  <= 4'b0000;
          err_q   <= l_err;
          rdata_q <= (!l_we && !l_err) ? ext_data : 32'd0;
          state   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps a reset that lands mid-ACCESS from committing the write
  assign bus.sram_w_en  = w_en_q & {4{rst_n}};
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a byte-array SRAM model.
module tb_dmem_access_unit;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         errors;
  int         checks;
  logic [7:0] mem [0:65535];

  dmem_access_unit_if #(.ADDR_W(16)) bus_if ();

  dmem_access_unit #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational read, byte-enabled write on posedge
  logic [15:0] a0, a1, a2, a3;
  assign a0 = bus_if.sram_addr;
  assign a1 = bus_if.sram_addr + 16'd1;
  assign a2 = bus_if.sram_addr + 16'd2;
  assign a3 = bus_if.sram_addr + 16'd3;
  assign bus_if.sram_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    if (bus_if.sram_w_en[0]) mem[a0] <= bus_if.sram_wdata[7:0];
    if (bus_if.sram_w_en[1]) mem[a1] <= bus_if.sram_wdata[15:8];
    if (bus_if.sram_w_en[2]) mem[a2] <= bus_if.sram_wdata[23:16];
    if (bus_if.sram_w_en[3]) mem[a3] <= bus_if.sram_wdata[31:24];
  end

  // driver: one full transaction, rsp_ready raised as soon as the response appears
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        output logic [3:0] wen_acc, output logic [3:0] wen_rsp,
                        output logic valid2, output logic [31:0] rdata, output logic err);
    int n;
    wen_acc = 4'hx; wen_rsp = 4'hx; valid2 = 1'b0; rdata = 32'hx; err = 1'bx;
    @(negedge clk);
    bus_if.req_we = we; bus_if.req_size = size; bus_if.req_unsigned = uns;
    bus_if.req_addr = addr; bus_if.req_wdata = wdata; bus_if.req_valid = 1'b1;
    n = 0;
    while (!bus_if.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus_if.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, bus_if.req_ready);
      bus_if.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    wen_acc = bus_if.sram_w_en;
    @(negedge clk);
    valid2  = bus_if.rsp_valid;
    wen_rsp = bus_if.sram_w_en;
    n = 0;
    while (!bus_if.rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!bus_if.rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout addr=%h rsp_valid=%b required 1", addr, bus_if.rsp_valid);
      return;
    end
    rdata = bus_if.rsp_rdata;
    err   = bus_if.rsp_err;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
  endtask

  logic [3:0]  wa, wr;
  logic        v2, e;
  logic [31:0] rd;

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", bus_if.rsp_valid); end
    checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", bus_if.req_ready); end
    checks++; if (bus_if.sram_w_en !== 4'b0000) begin errors++; $display("FAIL rst_w_en got %b want 0000", bus_if.sram_w_en); end
    checks++; if ({bus_if.sram_addr, bus_if.sram_wdata} !== 48'd0) begin errors++; $display("FAIL rst_sram got %h/%h want 0/0", bus_if.sram_addr, bus_if.sram_wdata); end
    checks++; if ({bus_if.rsp_rdata, bus_if.rsp_err} !== 33'd0) begin errors++; $display("FAIL rst_rsp got %h/%b want 0/0", bus_if.rsp_rdata, bus_if.rsp_err); end
    checks++; if (state_dbg !== 2'b00) begin errors++; $display("FAIL rst_state got %b want 00", state_dbg); end
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    do_txn(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, wa, wr, v2, rd, e);
    checks++; if (wa !== 4'b1111) begin errors++; $display("FAIL sw_wen_access got %b want 1111", wa); end
    checks++; if (wr !== 4'b0000) begin errors++; $display("FAIL sw_wen_resp got %b want 0000", wr); end
    checks++; if ({rd, e} !== 33'd0) begin errors++; $display("FAIL sw_rsp got %h/%b want 0/0", rd, e); end
    do_txn(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, wa, wr, v2, rd, e);
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL lw_latency rsp_valid got %b want 1", v2); end
    checks++; if (wa !== 4'b0000) begin errors++; $display("FAIL lw_wen got %b want 0000", wa); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_data got %h/%b want deadbeef/0", rd, e); end
  endtask

  task automatic test_byte;
    do_txn(1'b1, 2'b00, 1'b0, 16'h0013, 32'h00000080, wa, wr, v2, rd, e);
    checks++; if (wa !== 4'b0001) begin errors++; $display("FAIL sb_wen got %b want 0001", wa); end
    do_txn(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h want ffffff80", rd); end
    do_txn(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", rd); end
    do_txn(1'b0, 2'b00, 1'b0, 16'h0010, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_0010 got %h want ffffffef", rd); end
    do_txn(1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL lbu_0011 got %h want 000000be", rd); end
    do_txn(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_merged got %h want 80adbeef", rd); end
  endtask

  task automatic test_half;
    do_txn(1'b1, 2'b01, 1'b0, 16'h0020, 32'h00008001, wa, wr, v2, rd, e);
    checks++; if (wa !== 4'b0011) begin errors++; $display("FAIL sh_wen got %b want 0011", wa); end
    do_txn(1'b0, 2'b01, 1'b0, 16'h0020, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_signed got %h want ffff8001", rd); end
    do_txn(1'b0, 2'b01, 1'b1, 16'h0020, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu got %h want 00008001", rd); end
  endtask

  task automatic test_errors;
    do_txn(1'b1, 2'b10, 1'b0, 16'hFFFE, 32'h12345678, wa, wr, v2, rd, e);
    checks++; if ({wa, wr} !== 8'h00) begin errors++; $display("FAIL ovf_store_wen got %b/%b want 0000/0000", wa, wr); end
    checks++; if (e !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL ovf_store_rsp got %h/%b want 0/1", rd, e); end
    do_txn(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, wa, wr, v2, rd, e);
    checks++; if (e !== 1'b1 || rd !== 32'd0 || wa !== 4'b0000) begin errors++; $display("FAIL size11 got %h/%b/%b want 0/1/0000", rd, e, wa); end
    do_txn(1'b1, 2'b11, 1'b0, 16'h0010, 32'h0, wa, wr, v2, rd, e);
    checks++; if (e !== 1'b1 || wa !== 4'b0000) begin errors++; $display("FAIL size11_store got %b/%b want 1/0000", e, wa); end
    do_txn(1'b0, 2'b10, 1'b0, 16'hFFFC, 32'h0, wa, wr, v2, rd, e);
    checks++; if (e !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL top_word got %h/%b want 0/0", rd, e); end
    do_txn(1'b0, 2'b01, 1'b0, 16'hFFFF, 32'h0, wa, wr, v2, rd, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ovf_half got %b want 1", e); end
    do_txn(1'b1, 2'b00, 1'b0, 16'hFFFF, 32'h5A, wa, wr, v2, rd, e);
    checks++; if (e !== 1'b0 || wa !== 4'b0001) begin errors++; $display("FAIL top_byte got %b/%b want 0/0001", e, wa); end
  endtask

  task automatic test_hold;
    logic [31:0] first;
    bus_if.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state_dbg !== 2'b00 || bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_ready state=%b valid=%b want 00/0", state_dbg, bus_if.rsp_valid); end
    bus_if.rsp_ready = 1'b0;
    bus_if.req_we = 1'b0; bus_if.req_size = 2'b10; bus_if.req_unsigned = 1'b0;
    bus_if.req_addr = 16'h0010; bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    first = bus_if.rsp_rdata;
    checks++; if (bus_if.rsp_valid !== 1'b1 || first !== 32'h80ADBEEF) begin errors++; $display("FAIL hold_first valid=%b data=%h want 1/80adbeef", bus_if.rsp_valid, first); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'h80ADBEEF || bus_if.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d valid=%b data=%h req_ready=%b want 1/80adbeef/0", i, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.req_ready);
      end
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    checks++; if (state_dbg !== 2'b00 || bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release state=%b req_ready=%b valid=%b want 00/1/0", state_dbg, bus_if.req_ready, bus_if.rsp_valid); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus_if.req_we = 1'b1; bus_if.req_size = 2'b10; bus_if.req_unsigned = 1'b0;
    bus_if.req_addr = 16'h0040; bus_if.req_wdata = 32'h11223344; bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    checks++; if (state_dbg !== 2'b01) begin errors++; $display("FAIL midrst_in_access state=%b want 01", state_dbg); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.sram_w_en !== 4'b0000) begin errors++; $display("FAIL midrst_wen got %b want 0000", bus_if.sram_w_en); end
    @(negedge clk);
    checks++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.sram_w_en !== 4'b0000 || bus_if.sram_addr !== 16'd0 ||
        bus_if.sram_wdata !== 32'd0 || bus_if.rsp_rdata !== 32'd0 || bus_if.rsp_err !== 1'b0 || state_dbg !== 2'b00) begin
      errors++;
      $display("FAIL midrst_outputs valid=%b wen=%b addr=%h wdata=%h rdata=%h err=%b state=%b want all 0",
               bus_if.rsp_valid, bus_if.sram_w_en, bus_if.sram_addr, bus_if.sram_wdata,
               bus_if.rsp_rdata, bus_if.rsp_err, state_dbg);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp%0d got %b want 0", i, bus_if.rsp_valid); end
    end
    do_txn(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL midrst_no_write got %h/%b want 0/0", rd, e); end
  endtask

  task automatic test_misalign;
    do_txn(1'b1, 2'b10, 1'b0, 16'h0021, 32'hCAFEF00D, wa, wr, v2, rd, e);
`ifdef DMEM_ALIGN_CHECK_EN
    checks++; if (e !== 1'b1 || wa !== 4'b0000 || rd !== 32'd0) begin errors++; $display("FAIL mis_store got err=%b wen=%b rd=%h want 1/0000/0", e, wa, rd); end
    do_txn(1'b0, 2'b00, 1'b1, 16'h0021, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL mis_unchanged got %h want 00000080", rd); end
`else
    checks++; if (e !== 1'b0 || wa !== 4'b1111) begin errors++; $display("FAIL mis_store got err=%b wen=%b want 0/1111", e, wa); end
    do_txn(1'b0, 2'b10, 1'b0, 16'h0021, 32'h0, wa, wr, v2, rd, e);
    checks++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL mis_load got %h/%b want cafef00d/0", rd, e); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_size = 2'b00;
    bus_if.req_unsigned = 1'b0; bus_if.req_addr = 16'h0; bus_if.req_wdata = 32'h0;
    bus_if.rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_hold();
    test_reset_mid();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
